// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: arbitrates one byte-wide, single-ported memory between the
// instruction-fetch port and the load/store port. Each access is split into
// byte cycles, little-endian. Load results are sign- or zero-extended.
module unified_mem_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_size,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, CAPT = 2'd2, RESP = 2'd3} state_t;

  state_t            state, state_nxt;
  logic              owner_d;       // 1 = data port owns the access in flight
  logic              last_grant_d;  // 1 = data port was served last
  logic              grant_d;
  logic              any_req;
  logic [1:0]        cnt;
  logic [1:0]        last_idx;
  logic [1:0]        prev_idx;
  logic [ADDR_W-1:0] base;
  logic [2:0]        size;
  logic              we;
  logic [31:0]       wdata;
  logic [31:0]       asm_word;
  logic [31:0]       rd_word;
  logic              unused_addr_hi;

  // Index of the final byte of the access: fetches and words use four bytes.
  function automatic logic [1:0] last_byte(input logic is_data, input logic [2:0] sz);
    if (!is_data || sz[1]) return 2'd3;
    else if (sz[0]) return 2'd1;
    else return 2'd0;
  endfunction

  // Sign- or zero-extend a byte/half load; sz[2] selects zero extension.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] sz);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = w[7:0];
    h = w[15:0];
    if (sz[1]) return w;
    if (sz[0]) begin
      if (sz[2]) return {16'h0000, w[15:0]};
      r = h;
      return r;
    end
    if (sz[2]) return {24'h000000, w[7:0]};
    r = b;
    return r;
  endfunction

  // Address bits above the memory size are ignored.
  assign unused_addr_hi = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

  assign any_req  = if_req | d_req;
  assign last_idx = last_byte(owner_d, size);
  assign prev_idx = cnt - 2'd1;

  // Round-robin on a tie: the port not served last wins.
  always_comb begin
    if (if_req && d_req) grant_d = !last_grant_d;
    else                 grant_d = d_req;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: stores skip CAPT since no read data is pending.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = XFER;
      XFER: if (cnt == last_idx) state_nxt = we ? RESP : CAPT;
      CAPT: state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: memory bus is driven only during XFER, ready only in RESP.
  always_comb begin
    if_ready  = 1'b0;
    d_ready   = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      XFER: begin
        mem_addr = base + ADDR_W'(cnt);
        mem_we   = we;
        if (we) mem_wdata = wdata[{cnt, 3'b000} +: 8];
      end
      RESP: begin
        if_ready = !owner_d;
        d_ready  = owner_d;
      end
      default: ;
    endcase
  end

  // Control registers: byte counter, owner and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      owner_d      <= 1'b0;
      last_grant_d <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (any_req) owner_d <= grant_d;
        end
        XFER:    cnt <= cnt + 2'd1;
        RESP:    last_grant_d <= owner_d;
        default: ;
      endcase
    end
  end

  // Request fields are latched at grant; read bytes arrive one cycle after their address.
  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      base     <= grant_d ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
      size     <= d_size;
      we       <= grant_d & d_we;
      wdata    <= d_wdata;
      asm_word <= '0;
    end else if (state == XFER && !we && cnt != 2'd0) begin
      asm_word[{prev_idx, 3'b000} +: 8] <= mem_rdata;
    end
  end

  // Merge the final byte straight from memory so the result is ready on entry to RESP.
  always_comb begin
    rd_word = asm_word;
    rd_word[{last_idx, 3'b000} +: 8] = mem_rdata;
  end

  // Response data registers hold until the next response on the same port.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (state == CAPT) begin
      if (owner_d) d_rdata  <= load_extend(rd_word, size);
      else         if_rdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Testbench for unified_mem_ctrl: byte-array memory model plus a transaction-level
// reference memory; directed scenarios followed by randomized accesses.
module tb_unified_mem_ctrl;
  localparam int AW  = 12;
  localparam int MSZ = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_ready;
  logic [31:0]   if_rdata;
  logic          d_req;
  logic          d_we;
  logic [2:0]    d_size;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic          d_ready;
  logic [31:0]   d_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  logic [7:0]    mem [MSZ];
  logic [7:0]    ref_mem [MSZ];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [7:0]    bd_data;

  int n_checks = 0;
  int n_fail   = 0;
  int both_ready = 0;
  logic [AW-1:0] addr_log[$];
  int we_cycles;

  unified_mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous byte memory with a backdoor write port for preloading.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) if (if_ready && d_ready) both_ready++;

  function automatic int nbytes(input bit fetch, input logic [2:0] sz);
    if (fetch || sz[1]) return 4;
    return sz[0] ? 2 : 1;
  endfunction

  function automatic logic [31:0] ref_load(input int a, input int n, input bit uns);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[(a + i) % MSZ]) << (8 * i);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic ref_store(input int a, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) ref_mem[(a + i) % MSZ] = d[8 * i +: 8];
  endtask

  task automatic poke(input int a, input logic [7:0] v);
    bd_addr = AW'(a);
    bd_data = v;
    bd_we   = 1'b1;
    @(posedge clk); #1;
    bd_we   = 1'b0;
    ref_mem[a] = v;
  endtask

  // Issue one access and wait (bounded) for its ready; lat = cycles from the IDLE cycle.
  task automatic do_access(input bit fetch, input bit we, input logic [2:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat);
    bit done = 0;
    @(posedge clk); #1;
    addr_log.delete();
    we_cycles = 0;
    if (fetch) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_size = sz; d_addr = addr; d_wdata = wd;
    end
    lat = 0;
    rd  = 'x;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (fetch ? if_ready : d_ready) begin
        rd = fetch ? if_rdata : d_rdata;
        done = 1;
      end else begin
        addr_log.push_back(mem_addr);
        if (mem_we) we_cycles++;
        if (fetch) if_addr = $urandom;
        else begin
          d_addr = $urandom; d_wdata = $urandom; d_size = 3'($urandom); d_we = 1'($urandom);
        end
      end
    end
    if (!done) lat = 99;
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({if_ready, d_ready, mem_we} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {if_ready, d_ready, mem_we});
    end
    n_checks++;
    if ({mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_membus: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
    end
    n_checks++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h %h expected 0", if_rdata, d_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    logic [31:0] rd;
    int lat;
    poke(0, 8'h83); poke(1, 8'h20); poke(2, 8'h00); poke(3, 8'h00);
    do_access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, rd, lat);
    n_checks++;
    if (lat !== 6) begin n_fail++; $display("FAIL fetch_latency: got %0d expected 6", lat); end
    n_checks++;
    if (rd !== 32'h00002083) begin n_fail++; $display("FAIL fetch_data: got %h expected 00002083", rd); end
    n_checks++;
    if (addr_log.size() < 4 || addr_log[0] !== 12'h000 || addr_log[1] !== 12'h001 ||
        addr_log[2] !== 12'h002 || addr_log[3] !== 12'h003) begin
      n_fail++; $display("FAIL fetch_addr_seq: got %p expected 0,1,2,3", addr_log);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    int lat;
    do_access(1'b0, 1'b1, 3'b000, 32'h8, 32'h12345680, rd, lat);
    ref_store(8, 1, 32'h12345680);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL sb_latency: got %0d expected 2", lat); end
    n_checks++;
    if (we_cycles !== 1) begin n_fail++; $display("FAIL sb_we_cycles: got %0d expected 1", we_cycles); end
    n_checks++;
    if (mem[8] !== 8'h80) begin n_fail++; $display("FAIL sb_mem: got %h expected 80", mem[8]); end
    do_access(1'b0, 1'b0, 3'b010, 32'h8, 32'h0, rd, lat);
    n_checks++;
    if (rd !== ref_load(8, 4, 1'b0) || rd[7:0] !== 8'h80) begin
      n_fail++; $display("FAIL lw_after_sb: got %h expected %h", rd, ref_load(8, 4, 1'b0));
    end
    do_access(1'b0, 1'b0, 3'b000, 32'h8, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb: got %h expected FFFFFF80", rd); end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d expected 3", lat); end
    do_access(1'b0, 1'b0, 3'b100, 32'h8, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu: got %h expected 00000080", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    int lat;
    do_access(1'b0, 1'b1, 3'b010, 32'h00000FFE, 32'hAABBCCDD, rd, lat);
    ref_store(12'hFFE, 4, 32'hAABBCCDD);
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL sw_latency: got %0d expected 5", lat); end
    n_checks++;
    if ({mem[1], mem[0], mem[12'hFFF], mem[12'hFFE]} !== 32'hAABBCCDD) begin
      n_fail++; $display("FAIL sw_wrap_mem: got %h%h%h%h expected AABBCCDD",
                         mem[1], mem[0], mem[12'hFFF], mem[12'hFFE]);
    end
    do_access(1'b0, 1'b0, 3'b010, 32'h00000FFE, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'hAABBCCDD) begin n_fail++; $display("FAIL lw_wrap: got %h expected AABBCCDD", rd); end
  endtask

  task automatic test_half_unaligned();
    logic [31:0] rd;
    int lat;
    poke(3, 8'h34); poke(4, 8'hF2);
    do_access(1'b0, 1'b0, 3'b001, 32'h3, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'hFFFFF234) begin n_fail++; $display("FAIL lh: got %h expected FFFFF234", rd); end
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL lh_latency: got %0d expected 4", lat); end
    do_access(1'b0, 1'b0, 3'b101, 32'h3, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h0000F234) begin n_fail++; $display("FAIL lhu: got %h expected 0000F234", rd); end
  endtask

  task automatic test_reset_mid();
    int seen_ready = 0;
    poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33); poke(12'h103, 8'h44);
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_size = 3'b010; d_addr = 32'h100; d_wdata = 32'hCAFEBABE;
    @(posedge clk); #1;   // XFER byte 0
    @(posedge clk); #1;   // XFER byte 1
    rst = 1'b1;
    d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({mem_we, d_ready, if_ready} !== 3'b000 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++; $display("FAIL rst_mid_bus: got we %b dr %b ir %b addr %h expected all 0",
                         mem_we, d_ready, if_ready, mem_addr);
    end
    n_checks++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL rst_mid_rdata: got %h %h expected 0", if_rdata, d_rdata);
    end
    for (int i = 0; i < 8; i++) begin
      if (d_ready || mem_we) seen_ready++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen_ready !== 0) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d expected 0", seen_ready); end
    n_checks++;
    if ({mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]} !== 32'h4433BABE) begin
      n_fail++; $display("FAIL rst_mid_mem: got %h%h%h%h expected 4433BABE",
                         mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]);
    end
    ref_store(12'h100, 2, 32'hCAFEBABE);
  endtask

  task automatic test_arbitration();
    int order[$];
    int when[$];
    int cyc = 0;
    int nf = 0;
    int nd = 0;
    int br0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    br0 = both_ready;
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_size = 3'b010; d_addr = 32'h300;
    while (order.size() < 4 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (if_ready) begin
        order.push_back(0); when.push_back(cyc); nf++;
        n_checks++;
        if (if_rdata !== ref_load(12'h200, 4, 1'b1)) begin
          n_fail++; $display("FAIL arb_fetch_data: got %h expected %h", if_rdata, ref_load(12'h200, 4, 1'b1));
        end
        if (nf == 2) if_req = 1'b0;
      end
      if (d_ready) begin
        order.push_back(1); when.push_back(cyc); nd++;
        n_checks++;
        if (d_rdata !== ref_load(12'h300, 4, 1'b0)) begin
          n_fail++; $display("FAIL arb_data_data: got %h expected %h", d_rdata, ref_load(12'h300, 4, 1'b0));
        end
        if (nd == 2) d_req = 1'b0;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    n_checks++;
    if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
      n_fail++; $display("FAIL arb_order: got %p expected F,D,F,D (0,1,0,1)", order);
    end
    n_checks++;
    if (when.size() != 4 || when[0] != 6 || when[1] != 13 || when[2] != 20 || when[3] != 27) begin
      n_fail++; $display("FAIL arb_timing: got %p expected 6,13,20,27", when);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (both_ready !== br0) begin
      n_fail++; $display("FAIL arb_both_ready: got %0d expected %0d", both_ready, br0);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp;
    logic [2:0]  sz;
    bit f, w;
    int n, lat, bad;
    for (int it = 0; it < 60; it++) begin
      f  = 1'($urandom_range(0, 1));
      w  = f ? 1'b0 : 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 7));
      a  = $urandom;
      wd = $urandom;
      n  = nbytes(f, sz);
      do_access(f, w, sz, a, wd, rd, lat);
      if (w) begin
        ref_store(int'(a[AW-1:0]), n, wd);
        bad = 0;
        for (int i = 0; i < n; i++)
          if (mem[(int'(a[AW-1:0]) + i) % MSZ] !== ref_mem[(int'(a[AW-1:0]) + i) % MSZ]) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL rnd_store_mem it %0d: got %0d bad bytes expected 0", it, bad); end
        n_checks++;
        if (lat != n + 1) begin n_fail++; $display("FAIL rnd_store_lat it %0d: got %0d expected %0d", it, lat, n + 1); end
      end else begin
        exp = ref_load(int'(a[AW-1:0]), n, f ? 1'b1 : sz[2]);
        n_checks++;
        if (rd !== exp) begin n_fail++; $display("FAIL rnd_load_data it %0d: got %h expected %h", it, rd, exp); end
        n_checks++;
        if (lat != n + 2) begin n_fail++; $display("FAIL rnd_load_lat it %0d: got %0d expected %0d", it, lat, n + 2); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < MSZ; i++) poke(i, 8'($urandom));
    test_reset();
    test_fetch();
    test_store_load();
    test_wrap();
    test_half_unaligned();
    test_reset_mid();
    test_arbitration();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
